// File: rtl/frame_stream_source.sv
// Frame-buffer reader: walks the frame in raster order and streams RGB101010
// pixels out through a 2-entry skid buffer under valid/ready flow control.
module frame_stream_source #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [11:0]       rd_data,
  output logic [29:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              frame_done
);

  localparam int CW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int RW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [11:0] rgb;
  } pix_t;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fl_q, fl_sop_q, fl_eop_q;
  pix_t              ent0_q, ent0_d;
  pix_t              ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              fd_q, fd_d;

  logic       pop, fetch, last_col, last_row;
  logic [1:0] after_pop;
  pix_t       new_pix;

  always_comb begin
    pop       = (cnt_q != 2'd0) && out_ready;
    after_pop = cnt_q - {1'b0, pop};
    // In-flight fetch counts as occupied so the buffer can never overflow.
    cnt_d     = after_pop + {1'b0, fl_q};
    fetch     = enable && (cnt_d < 2'd2);
    last_col  = (col_q == CW'(H_PIXELS - 1));
    last_row  = (row_q == RW'(V_LINES - 1));
    new_pix   = '{sop: fl_sop_q, eop: fl_eop_q, rgb: rd_data};

    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (fetch) begin
      if (last_col) begin
        col_d  = '0;
        row_d  = last_row ? '0 : row_q + 1'b1;
        addr_d = last_row ? '0 : addr_q + 1'b1;
      end else begin
        col_d  = col_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end

    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (pop) ent0_d = ent1_q;
    if (fl_q) begin
      if (after_pop == 2'd0) ent0_d = new_pix;
      else                   ent1_d = new_pix;
    end

    fd_d = pop && ent0_q.eop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      fl_q     <= 1'b0;
      fl_sop_q <= 1'b0;
      fl_eop_q <= 1'b0;
      ent0_q   <= '0;
      ent1_q   <= '0;
      cnt_q    <= 2'd0;
      fd_q     <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      fl_q     <= fetch;
      fl_sop_q <= (col_q == '0) && (row_q == '0);
      fl_eop_q <= last_col && last_row;
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      cnt_q    <= cnt_d;
      fd_q     <= fd_d;
    end
  end

  assign rd_address = addr_q;
  assign out_valid  = (cnt_q != 2'd0);
  assign out_sop    = out_valid && ent0_q.sop;
  assign out_eop    = out_valid && ent0_q.eop;
  assign frame_done = fd_q;
  assign out_data   = out_valid ?
    {ent0_q.rgb[11:8], ent0_q.rgb[11:8], 2'b00,
     ent0_q.rgb[7:4],  ent0_q.rgb[7:4],  2'b00,
     ent0_q.rgb[3:0],  ent0_q.rgb[3:0],  2'b00} : 30'd0;

endmodule
